data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the single-cycle core's data port. It receives MemWrite, ALUResult (used as the address) and WriteData, and returns ReadData.
- It decodes the address into a word-addressed data RAM and a small MMIO region.
- The MMIO region holds a console transmit FIFO, drained over a valid/ready stream, and a free-running timer with a compare-match interrupt flag.
- It sits beside the core at SoC top level, in place of a plain data memory.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words, power of 2, located at address 0.
- FIFO_DEPTH, 8, console FIFO entries, power of 2, at least 2.
- MMIO_BASE, 32'h1000_0000, base address of the MMIO register block.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  store strobe from the core.
- ALUResult  in  32  byte address from the core; bits [1:0] are ignored (word access only).
- WriteData  in  32  store data.
- ReadData  out  32  load data, combinational from ALUResult.
- tx_valid  out  1  console byte available.
- tx_data  out  8  console byte at the FIFO head.
- tx_ready  in  1  consumer accepts the byte.
- timer_irq  out  1  sticky timer match flag.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reads are combinational and free of side effects, because the core has no read strobe.
- Writes take effect at the rising edge where MemWrite=1.
- RAM region: address < RAM_WORDS*4.
  - Index is ALUResult[$clog2(RAM_WORDS)+1:2].
  - Asynchronous read, synchronous write.
  - Contents are not cleared by reset.
- MMIO register offsets from MMIO_BASE:
  - 0x00 CON_DATA
    - Write pushes WriteData[7:0] if the FIFO is not full, or if a pop occurs in the same cycle.
    - Otherwise the byte is dropped and the overflow flag is set.
    - Read returns 0.
  - 0x04 CON_STAT
    - Read returns {29'b0, overflow, full, empty}.
    - Writing with WriteData[2]=1 clears overflow.
    - If an overflow occurs in the same cycle as the clear, the set wins.
  - 0x08 TMR_COUNT
    - Read returns the counter.
    - Write loads WriteData; there is no increment in that cycle.
  - 0x0C TMR_CMP: read/write compare value.
  - 0x10 TMR_STAT
    - Read returns {31'b0, match}.
    - Writing with WriteData[0]=1 clears match.
    - If a match occurs in the same cycle as the clear, the set wins.
- Any other address: read returns 0, write is ignored.
- Console FIFO:
  - tx_valid = !empty; tx_data = head entry.
  - Pop happens when tx_valid && tx_ready.
  - Pointers carry one extra wrap bit for the full/empty distinction.
  - Pop while empty is a no-op.
  - Simultaneous push and pop when empty: tx_valid rises next cycle with the pushed byte.
  - Ordering is strictly FIFO.
- Timer:
  - Counter increments every cycle and wraps from 0xFFFF_FFFF to 0.
  - match is set at the edge following a cycle in which the counter register equals TMR_CMP.
  - timer_irq = match, registered directly with no combinational path.
- Reset values:
  - FIFO empty, overflow=0.
  - counter=0, TMR_CMP=0xFFFF_FFFF, match=0.
  - tx_valid=0, tx_data=0 (head storage cleared), timer_irq=0.
  - ReadData follows the address; MMIO reads reflect the reset register values.
  - Writes in a reset cycle are ignored.
  - Reset mid-stream discards FIFO contents; RAM is retained.
- Unaligned addresses alias to the enclosing word.

Decomposition:
- Shared package: MMIO offsets (CON_DATA, CON_STAT, TMR_COUNT, TMR_CMP, TMR_STAT), status bit positions, and TMR_CMP reset constant.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH), with push/pop/full/empty/head ports.
- Address decode, RAM and timer stay in the top module.

Test Plan:
- RAM: write 0x0000_0010 = 0xCAFE_BABE -> read 0x10 returns 0xCAFE_BABE, 0x13 aliases the same word, 0x14 unchanged; read 0x1000_0020 returns 0.
- Console: with tx_ready=0, write 0x41 then 0x42 -> tx_valid=1, tx_data=0x41, CON_STAT=0.
  - Then raise tx_ready -> 0x41 then 0x42 transfer on consecutive cycles, then tx_valid=0 and CON_STAT=1.
- Overflow: tx_ready=0, push 8 bytes -> CON_STAT=0b010.
  - 9th push -> byte dropped, CON_STAT=0b110.
  - Write 0x4 to CON_STAT -> 0b010; drained order is the first 8 bytes.
- Full plus simultaneous pop: full FIFO, tx_ready=1, push 0x55 -> accepted, no overflow, 0x55 emerges last.
- Timer:
  - Write TMR_CMP=20, then TMR_COUNT=10 at edge t -> timer_irq rises at edge t+11.
  - Writing 1 to TMR_STAT -> timer_irq low next cycle.
  - Load 0xFFFF_FFFE -> reads 0 two cycles later (wrap).
- Reset mid-operation: 3 bytes queued and match=1, pulse reset one cycle -> tx_valid=0, timer_irq=0, counter=0, TMR_CMP=0xFFFF_FFFF, RAM word at 0x10 still 0xCAFE_BABE.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: MMIO register map,
// status bit positions and timer reset constants.
package data_mem_responder_pkg;

  // Byte offsets of the MMIO registers relative to the MMIO base
  localparam logic [4:0] OFF_CON_DATA  = 5'h00;
  localparam logic [4:0] OFF_CON_STAT  = 5'h04;
  localparam logic [4:0] OFF_TMR_COUNT = 5'h08;
  localparam logic [4:0] OFF_TMR_CMP   = 5'h0C;
  localparam logic [4:0] OFF_TMR_STAT  = 5'h10;

  // CON_STAT / TMR_STAT bit positions
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int TMR_MATCH_BIT  = 0;

  localparam logic [31:0] TMR_CMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    REG_CON_DATA,
    REG_CON_STAT,
    REG_TMR_COUNT,
    REG_TMR_CMP,
    REG_TMR_STAT,
    REG_NONE
  } mmio_reg_e;

  // Map a word offset (address minus base, already shifted right by 2)
  // onto a register; anything outside the five registers is REG_NONE.
  function automatic mmio_reg_e mmio_decode(input logic [29:0] word_off);
    mmio_reg_e r;
    r = REG_NONE;
    if (word_off[29:3] == '0) begin
      case ({word_off[2:0], 2'b00})
        OFF_CON_DATA:  r = REG_CON_DATA;
        OFF_CON_STAT:  r = REG_CON_STAT;
        OFF_TMR_COUNT: r = REG_TMR_COUNT;
        OFF_TMR_CMP:   r = REG_TMR_CMP;
        OFF_TMR_STAT:  r = REG_TMR_STAT;
        default:       r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers. Head is read combinationally;
// a push into a full FIFO is accepted only when a pop happens in the same
// cycle. Storage is cleared on reset so the head reads zero afterwards.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[AW-1:0]];

  // Pointer advance and storage write; reset empties and clears storage
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + PTR_ONE;
      end
      if (do_pop) rptr <= rptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder for the single-cycle core: word RAM at address 0,
// plus an MMIO block with a console TX FIFO and a compare-match timer.
// Reads are combinational and side-effect free; writes land on the edge.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]       ram [RAM_WORDS];
  logic              ram_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [29:0]       word_off;
  mmio_reg_e         reg_sel;

  logic        wr;
  logic        con_wr;
  logic        cstat_wr;
  logic        tcnt_wr;
  logic        tcmp_wr;
  logic        tstat_wr;

  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        ovf_evt;
  logic        overflow;

  logic [31:0] count;
  logic [31:0] cmp;
  logic        match;

  // MMIO_BASE is word aligned, so dropping bits [1:0] gives unaligned aliasing
  assign ram_sel  = (ALUResult < RAM_BYTES);
  assign ram_idx  = ALUResult[RAM_AW+1:2];
  assign word_off = ALUResult[31:2] - MMIO_BASE[31:2];
  assign reg_sel  = ram_sel ? REG_NONE : mmio_decode(word_off);

  assign wr       = MemWrite && !reset;
  assign con_wr   = wr && (reg_sel == REG_CON_DATA);
  assign cstat_wr = wr && (reg_sel == REG_CON_STAT);
  assign tcnt_wr  = wr && (reg_sel == REG_TMR_COUNT);
  assign tcmp_wr  = wr && (reg_sel == REG_TMR_CMP);
  assign tstat_wr = wr && (reg_sel == REG_TMR_STAT);

  assign tx_valid  = !fifo_empty;
  assign fifo_pop  = tx_valid && tx_ready;
  // A full FIFO still takes the byte when the head leaves in the same cycle
  assign ovf_evt   = con_wr && fifo_full && !fifo_pop;
  assign timer_irq = match;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (con_wr),
    .pop   (fifo_pop),
    .din   (WriteData[7:0]),
    .head  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // RAM store; contents survive reset
  always_ff @(posedge clk) begin
    if (wr && ram_sel) ram[ram_idx] <= WriteData;
  end

  // Overflow flag, free-running timer and sticky match flag (set beats clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      count    <= '0;
      cmp      <= TMR_CMP_RST;
      match    <= 1'b0;
    end else begin
      if (ovf_evt)                                   overflow <= 1'b1;
      else if (cstat_wr && WriteData[STAT_OVF_BIT])  overflow <= 1'b0;

      count <= tcnt_wr ? WriteData : count + 32'd1;

      if (tcmp_wr) cmp <= WriteData;

      if (count == cmp)                              match <= 1'b1;
      else if (tstat_wr && WriteData[TMR_MATCH_BIT]) match <= 1'b0;
    end
  end

  // Load data mux
  always_comb begin
    ReadData = '0;
    if (ram_sel) begin
      ReadData = ram[ram_idx];
    end else begin
      case (reg_sel)
        REG_CON_STAT: begin
          ReadData[STAT_EMPTY_BIT] = fifo_empty;
          ReadData[STAT_FULL_BIT]  = fifo_full;
          ReadData[STAT_OVF_BIT]   = overflow;
        end
        REG_TMR_COUNT: ReadData = count;
        REG_TMR_CMP:   ReadData = cmp;
        REG_TMR_STAT:  ReadData[TMR_MATCH_BIT] = match;
        default:       ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios with literal expectations,
// then randomized traffic, all checked against a queue-based model.
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_CD = BASE + 32'h00;
  localparam logic [31:0] A_CS = BASE + 32'h04;
  localparam logic [31:0] A_TC = BASE + 32'h08;
  localparam logic [31:0] A_TM = BASE + 32'h0C;
  localparam logic [31:0] A_TS = BASE + 32'h10;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        timer_irq;

  data_mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  logic [7:0]  q[$];
  logic        m_ovf;
  logic [31:0] m_cnt;
  logic [31:0] m_cmp;
  logic        m_match;
  logic [31:0] ram_m [64];
  bit          known [64];
  bit          mv;
  logic [7:0]  drained[$];

  int total;
  int bad;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] o;
    if (a < 32'd256) return ram_m[a[7:2]];
    o = (a & ~32'h3) - BASE;
    case (o)
      32'h04:  return {29'b0, m_ovf, 1'(q.size() == 8), 1'(q.size() == 0)};
      32'h08:  return m_cnt;
      32'h0C:  return m_cmp;
      32'h10:  return {31'b0, m_match};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit predictable(input logic [31:0] a);
    if (a < 32'd256) return known[a[7:2]];
    return 1'b1;
  endfunction

  // advance the model by one clock edge using the inputs presented at it
  task automatic model_step();
    logic [31:0] wa;
    bit          pop;
    bit          set_m;
    bit          clr_m;
    bit          clr_o;
    bit          ovf_set;
    int          n;
    if (reset) begin
      q.delete();
      m_ovf   = 1'b0;
      m_cnt   = 32'h0;
      m_cmp   = 32'hFFFF_FFFF;
      m_match = 1'b0;
      mv      = 1'b1;
      return;
    end
    wa      = ALUResult & ~32'h3;
    n       = q.size();
    pop     = (n > 0) && tx_ready;
    set_m   = (m_cnt == m_cmp);
    clr_o   = MemWrite && (wa == A_CS) && WriteData[2];
    clr_m   = MemWrite && (wa == A_TS) && WriteData[0];
    ovf_set = 1'b0;
    if (pop) void'(q.pop_front());
    if (MemWrite && wa == A_CD) begin
      if (n < 8 || pop) q.push_back(WriteData[7:0]);
      else ovf_set = 1'b1;
    end
    m_ovf   = ovf_set ? 1'b1 : (clr_o ? 1'b0 : m_ovf);
    m_match = set_m ? 1'b1 : (clr_m ? 1'b0 : m_match);
    if (MemWrite && wa == A_TC) m_cnt = WriteData;
    else m_cnt = m_cnt + 32'd1;
    if (MemWrite && wa == A_TM) m_cmp = WriteData;
    if (MemWrite && ALUResult < 32'd256) begin
      ram_m[ALUResult[7:2]] = WriteData;
      known[ALUResult[7:2]] = 1'b1;
    end
  endtask

  task automatic tick(input bit we, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = we;
    ALUResult = a;
    WriteData = d;
    @(posedge clk);
    model_step();
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, ALUResult, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    ALUResult = a;
    #1;
    v = ReadData;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 255));
      1, 2:    return BASE + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
      default: return $urandom_range(0, 1) ? BASE + 32'h14 + 32'(4 * $urandom_range(0, 10))
                                           : 32'h100 + 32'($urandom_range(0, 1023));
    endcase
  endfunction

  // per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (mv) begin
      chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
      chk("timer_irq", 32'(timer_irq), 32'(m_match));
      if (predictable(ALUResult)) chk("ReadData", ReadData, model_read(ALUResult));
      if (tx_valid && tx_ready) drained.push_back(tx_data);
    end
  end

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    logic [31:0] d;
    int          k;
    total     = 0;
    bad       = 0;
    mv        = 1'b0;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    ALUResult = 32'h0;
    WriteData = 32'h0;
    tx_ready  = 1'b0;
    tick(1'b1, A_CD, 32'h77);
    idle();
    reset = 1'b0;

    // reset state
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_irq", 32'(timer_irq), 32'h0);
    rd(A_CS, v); chk("rst_con_stat", v, 32'h1);
    rd(A_TC, v); chk("rst_count", v, 32'h0);
    rd(A_TM, v); chk("rst_cmp", v, 32'hFFFF_FFFF);

    // RAM
    tick(1'b1, 32'h14, 32'h1234_5678);
    tick(1'b1, 32'h10, 32'hCAFE_BABE);
    rd(32'h10, v);        chk("ram_10", v, 32'hCAFE_BABE);
    rd(32'h13, v);        chk("ram_13_alias", v, 32'hCAFE_BABE);
    rd(32'h14, v);        chk("ram_14", v, 32'h1234_5678);
    rd(32'h1000_0020, v); chk("unmapped", v, 32'h0);

    // console basic
    tx_ready = 1'b0;
    tick(1'b1, A_CD, 32'h41);
    tick(1'b1, A_CD, 32'h42);
    chk("con_valid", 32'(tx_valid), 32'h1);
    chk("con_head", 32'(tx_data), 32'h41);
    rd(A_CS, v); chk("con_stat_2", v, 32'h0);
    drained.delete();
    tx_ready = 1'b1;
    idle();
    chk("con_head2", 32'(tx_data), 32'h42);
    idle();
    chk("con_valid_end", 32'(tx_valid), 32'h0);
    rd(A_CS, v); chk("con_stat_end", v, 32'h1);
    tx_ready = 1'b0;
    chk("con_drained_n", 32'(drained.size()), 32'd2);
    if (drained.size() == 2) begin
      chk("con_drain0", 32'(drained[0]), 32'h41);
      chk("con_drain1", 32'(drained[1]), 32'h42);
    end

    // overflow
    for (int i = 1; i <= 8; i++) tick(1'b1, A_CD, 32'(i));
    rd(A_CS, v); chk("ovf_full", v, 32'h2);
    tick(1'b1, A_CD, 32'h9);
    rd(A_CS, v); chk("ovf_set", v, 32'h6);
    tick(1'b1, A_CS, 32'h4);
    rd(A_CS, v); chk("ovf_clr", v, 32'h2);
    drained.delete();
    tx_ready = 1'b1;
    for (int i = 0; i < 9; i++) idle();
    tx_ready = 1'b0;
    chk("ovf_drained_n", 32'(drained.size()), 32'd8);
    if (drained.size() == 8)
      for (int i = 0; i < 8; i++) chk("ovf_order", 32'(drained[i]), 32'(i + 1));

    // full plus simultaneous pop
    for (int i = 0; i < 8; i++) tick(1'b1, A_CD, 32'h11 + 32'(i));
    drained.delete();
    tx_ready = 1'b1;
    tick(1'b1, A_CD, 32'h55);
    rd(A_CS, v); chk("fullpop_stat", v, 32'h2);
    for (int i = 0; i < 8; i++) idle();
    tx_ready = 1'b0;
    chk("fullpop_n", 32'(drained.size()), 32'd9);
    if (drained.size() == 9) begin
      chk("fullpop_first", 32'(drained[0]), 32'h11);
      chk("fullpop_last", 32'(drained[8]), 32'h55);
    end
    rd(A_CS, v); chk("fullpop_empty", v, 32'h1);

    // timer match latency
    tick(1'b1, A_TC, 32'd1000);
    tick(1'b1, A_TM, 32'd20);
    tick(1'b1, A_TS, 32'h1);
    tick(1'b1, A_TC, 32'd10);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (timer_irq) begin
        k = i;
        break;
      end
    end
    chk("tmr_latency", 32'(k), 32'd11);
    tick(1'b1, A_TS, 32'h1);
    chk("tmr_clear", 32'(timer_irq), 32'h0);
    tick(1'b1, A_TC, 32'hFFFF_FFFE);
    idle();
    idle();
    rd(A_TC, v); chk("tmr_wrap", v, 32'h0);

    // reset mid-operation
    tick(1'b1, A_CD, 32'hA1);
    tick(1'b1, A_CD, 32'hA2);
    tick(1'b1, A_CD, 32'hA3);
    tick(1'b1, A_TM, 32'd100);
    tick(1'b1, A_TC, 32'd100);
    idle();
    chk("pre_rst_irq", 32'(timer_irq), 32'h1);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(tx_valid), 32'h0);
    chk("mid_rst_irq", 32'(timer_irq), 32'h0);
    chk("mid_rst_txdata", 32'(tx_data), 32'h0);
    rd(A_TC, v);   chk("mid_rst_count", v, 32'h0);
    rd(A_TM, v);   chk("mid_rst_cmp", v, 32'hFFFF_FFFF);
    rd(32'h10, v); chk("mid_rst_ram", v, 32'hCAFE_BABE);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      tx_ready = 1'($urandom_range(0, 1));
      a = rand_addr();
      d = $urandom;
      if (((a & ~32'h3) == A_TM) && $urandom_range(0, 1)) d = m_cnt + 32'($urandom_range(0, 20));
      tick($urandom_range(0, 2) != 0, a, d);
    end
    reset    = 1'b0;
    tx_ready = 1'b0;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
